// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types and the base/mask address decode used by register-mapped slaves.
package axi4l_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi4l_resp_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_ADDR = 2'b01,
        W_DATA = 2'b10,
        W_RESP = 2'b11
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Hit when the masked upper bits match the base and no unmasked bit above the low field is set.
    function automatic logic addr_hit(
        input logic [63:0] addr,
        input logic [63:0] base,
        input logic [63:0] mask,
        input int unsigned low_bits
    );
        logic [63:0] low_mask;
        low_mask = (64'd1 << low_bits) - 64'd1;
        return ((addr & mask) == base) && ((addr & ~mask & ~low_mask) == 64'd0);
    endfunction

endpackage

// File: rtl/axi4l_reg_slave_decode.sv
// Combinational address decode: register index plus hit/miss for one AXI4-Lite channel.
module axi4l_reg_slave_decode
    import axi4l_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter logic [63:0] BASE_OFFSET      = 64'h0,
    parameter logic [63:0] BASE_OFFSET_MASK = 64'h0,
    parameter int unsigned NUM_REGS         = 8,
    localparam int unsigned IDX_W           = $clog2(NUM_REGS)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [IDX_W-1:0]      idx,
    output logic                  hit
);

    logic [63:0] addr_ext_s;

    // Byte-offset bits [1:0] never reach the index; everything above the index field feeds the hit test.
    always_comb begin
        addr_ext_s = 64'(addr);
        idx        = addr[IDX_W+1:2];
        hit        = addr_hit(addr_ext_s, BASE_OFFSET, BASE_OFFSET_MASK, IDX_W + 32'd2);
    end

endmodule

// File: rtl/axi4l_reg_slave.sv
// AXI4-Lite responder exposing NUM_REGS 32-bit control registers.
// Optional byte-strobe support is enabled by defining AXI4L_REG_SLAVE_WSTRB_EN.
module axi4l_reg_slave
    import axi4l_pkg::*;
#(
    parameter logic [63:0] BASE_OFFSET      = 64'h0,
    parameter logic [63:0] BASE_OFFSET_MASK = 64'h0,
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned NUM_REGS         = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [ADDR_WIDTH-1:0]    awaddr,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [31:0]              wdata,
    input  logic [3:0]               wstrb,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    input  logic [ADDR_WIDTH-1:0]    araddr,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [31:0]              rdata,
    output logic [1:0]               rresp,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [NUM_REGS*32-1:0]   regs,
    output logic [NUM_REGS-1:0]      wr_pulse
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("axi4l_reg_slave: DATA_WIDTH must be 32");
        end
        if ((NUM_REGS < 2) || (NUM_REGS > 256) || ((NUM_REGS & (NUM_REGS - 1)) != 0)) begin : g_bad_num_regs
            $error("axi4l_reg_slave: NUM_REGS must be a power of two from 2 to 256");
        end
    endgenerate

    wr_state_t             wr_state_r;
    rd_state_t             rd_state_r;
    logic                  ready_en_r;
    logic                  aw_open_r;
    logic                  w_open_r;
    logic                  ar_open_r;
    logic                  bvalid_r;
    logic                  rvalid_r;
    axi4l_resp_t           bresp_r;
    axi4l_resp_t           rresp_r;
    logic [31:0]           rdata_r;
    logic [ADDR_WIDTH-1:0] awaddr_hold_r;
    logic [31:0]           wdata_hold_r;
    logic [3:0]            wstrb_hold_r;
    logic [31:0]           regs_r [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_pulse_r;

    logic                  aw_hs_s;
    logic                  w_hs_s;
    logic                  ar_hs_s;
    logic                  commit_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic [31:0]           wr_data_s;
    logic [3:0]            wr_strb_s;
    logic [31:0]           wr_merged_s;
    logic [IDX_W-1:0]      wr_idx_s;
    logic [IDX_W-1:0]      rd_idx_s;
    logic                  wr_hit_s;
    logic                  rd_hit_s;

    // Readies are gated by ready_en_r so they only appear one edge after reset release.
    assign awready  = ready_en_r & aw_open_r;
    assign wready   = ready_en_r & w_open_r;
    assign arready  = ready_en_r & ar_open_r;
    assign bvalid   = bvalid_r;
    assign bresp    = bresp_r;
    assign rvalid   = rvalid_r;
    assign rdata    = rdata_r;
    assign rresp    = rresp_r;
    assign wr_pulse = wr_pulse_r;

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_flatten
            assign regs[32*g +: 32] = regs_r[g];
        end
    endgenerate

    axi4l_reg_slave_decode #(
        .ADDR_WIDTH       (ADDR_WIDTH),
        .BASE_OFFSET      (BASE_OFFSET),
        .BASE_OFFSET_MASK (BASE_OFFSET_MASK),
        .NUM_REGS         (NUM_REGS)
    ) u_wr_decode (
        .addr (wr_addr_s),
        .idx  (wr_idx_s),
        .hit  (wr_hit_s)
    );

    axi4l_reg_slave_decode #(
        .ADDR_WIDTH       (ADDR_WIDTH),
        .BASE_OFFSET      (BASE_OFFSET),
        .BASE_OFFSET_MASK (BASE_OFFSET_MASK),
        .NUM_REGS         (NUM_REGS)
    ) u_rd_decode (
        .addr (araddr),
        .idx  (rd_idx_s),
        .hit  (rd_hit_s)
    );

    // Handshakes, plus selection of the held or live half of a write on the completing edge.
    always_comb begin
        aw_hs_s   = awvalid & awready;
        w_hs_s    = wvalid & wready;
        ar_hs_s   = arvalid & arready;
        wr_addr_s = awaddr;
        wr_data_s = wdata;
        wr_strb_s = wstrb;
        commit_s  = 1'b0;
        case (wr_state_r)
            W_IDLE: begin
                commit_s = aw_hs_s & w_hs_s;
            end
            W_ADDR: begin
                wr_addr_s = awaddr_hold_r;
                commit_s  = w_hs_s;
            end
            W_DATA: begin
                wr_data_s = wdata_hold_r;
                wr_strb_s = wstrb_hold_r;
                commit_s  = aw_hs_s;
            end
            W_RESP: begin
                commit_s = 1'b0;
            end
            default: begin
                commit_s = 1'b0;
            end
        endcase
    end

`ifdef AXI4L_REG_SLAVE_WSTRB_EN
    // Byte lanes without a strobe keep the current register contents.
    always_comb begin
        wr_merged_s = regs_r[wr_idx_s];
        for (int b = 0; b < 4; b++) begin
            if (wr_strb_s[b]) begin
                wr_merged_s[8*b +: 8] = wr_data_s[8*b +: 8];
            end else begin
                wr_merged_s[8*b +: 8] = regs_r[wr_idx_s][8*b +: 8];
            end
        end
    end
`else
    assign wr_merged_s = wr_data_s;
    logic unused_strb_s;
    assign unused_strb_s = ^wr_strb_s;
`endif

    // Readies come up on the first edge after reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // Write FSM: collect AW and W in either order, then hold the response until accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_state_r    <= W_IDLE;
            aw_open_r     <= 1'b1;
            w_open_r      <= 1'b1;
            bvalid_r      <= 1'b0;
            bresp_r       <= OKAY;
            awaddr_hold_r <= {ADDR_WIDTH{1'b0}};
            wdata_hold_r  <= 32'h0;
            wstrb_hold_r  <= 4'h0;
        end else begin
            case (wr_state_r)
                W_IDLE: begin
                    if (commit_s) begin
                        wr_state_r <= W_RESP;
                        aw_open_r  <= 1'b0;
                        w_open_r   <= 1'b0;
                        bvalid_r   <= 1'b1;
                        bresp_r    <= wr_hit_s ? OKAY : SLVERR;
                    end else if (aw_hs_s) begin
                        wr_state_r    <= W_ADDR;
                        aw_open_r     <= 1'b0;
                        awaddr_hold_r <= awaddr;
                    end else if (w_hs_s) begin
                        wr_state_r   <= W_DATA;
                        w_open_r     <= 1'b0;
                        wdata_hold_r <= wdata;
                        wstrb_hold_r <= wstrb;
                    end
                end
                W_ADDR, W_DATA: begin
                    if (commit_s) begin
                        wr_state_r <= W_RESP;
                        aw_open_r  <= 1'b0;
                        w_open_r   <= 1'b0;
                        bvalid_r   <= 1'b1;
                        bresp_r    <= wr_hit_s ? OKAY : SLVERR;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        wr_state_r <= W_IDLE;
                        aw_open_r  <= 1'b1;
                        w_open_r   <= 1'b1;
                        bvalid_r   <= 1'b0;
                    end
                end
                default: begin
                    wr_state_r <= W_IDLE;
                    aw_open_r  <= 1'b1;
                    w_open_r   <= 1'b1;
                    bvalid_r   <= 1'b0;
                end
            endcase
        end
    end

    // Register file and write strobes; misses are dropped without a pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 32'h0;
            end
            wr_pulse_r <= {NUM_REGS{1'b0}};
        end else begin
            wr_pulse_r <= {NUM_REGS{1'b0}};
            if (commit_s && wr_hit_s) begin
                regs_r[wr_idx_s]     <= wr_merged_s;
                wr_pulse_r[wr_idx_s] <= 1'b1;
            end
        end
    end

    // Read FSM: capture data on AR, hold it stable until rready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_state_r <= R_IDLE;
            ar_open_r  <= 1'b1;
            rvalid_r   <= 1'b0;
            rdata_r    <= 32'h0;
            rresp_r    <= OKAY;
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        rd_state_r <= R_DATA;
                        ar_open_r  <= 1'b0;
                        rvalid_r   <= 1'b1;
                        rdata_r    <= rd_hit_s ? regs_r[rd_idx_s] : 32'h0;
                        rresp_r    <= rd_hit_s ? OKAY : SLVERR;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rd_state_r <= R_IDLE;
                        ar_open_r  <= 1'b1;
                        rvalid_r   <= 1'b0;
                    end
                end
                default: begin
                    rd_state_r <= R_IDLE;
                    ar_open_r  <= 1'b1;
                    rvalid_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4l_reg_slave.sv
// Scoreboard bench for axi4l_reg_slave: directed scenarios plus random traffic against an array model.
module tb_axi4l_reg_slave;

    localparam int NR = 8;
    localparam int RW = NR * 32;
`ifdef AXI4L_REG_SLAVE_WSTRB_EN
    localparam bit STRB_EN = 1'b1;
`else
    localparam bit STRB_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [31:0]   awaddr = 32'h0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [31:0]   wdata = 32'h0;
    logic [3:0]    wstrb = 4'h0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b1;
    logic [31:0]   araddr = 32'h0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready = 1'b1;
    logic [RW-1:0] regs;
    logic [NR-1:0] wr_pulse;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [31:0]   mdl [NR];
    logic [1:0]    exp_b [$];
    logic [33:0]   exp_r [$];
    bit            pre_b_bad;

    axi4l_reg_slave #(
        .BASE_OFFSET      (64'h0),
        .BASE_OFFSET_MASK (64'h0),
        .ADDR_WIDTH       (32),
        .DATA_WIDTH       (32),
        .NUM_REGS         (NR)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .awaddr   (awaddr),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .araddr   (araddr),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready),
        .regs     (regs),
        .wr_pulse (wr_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string name);
        logic [RW-1:0] e;
        for (int k = 0; k < NR; k++) e[32*k +: 32] = mdl[k];
        n_cmp++;
        if (regs !== e) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, regs, e);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no handshake within bound", name);
    endtask

    function automatic bit m_hit(input logic [31:0] a);
        return a < 32'(4 * NR);
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a >> 2) % 32'(NR));
    endfunction

    // B monitor: each accepted write response is checked against the oldest expectation.
    always @(negedge clk) begin
        if (rstn && bvalid && bready) begin
            if (exp_b.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b_unexpected: actual bresp=%0h required none", bresp);
            end else begin
                chk("bresp", 32'(bresp), 32'(exp_b.pop_front()));
            end
        end
    end

    // R monitor: each accepted read beat is checked against the oldest expectation.
    always @(negedge clk) begin
        logic [33:0] e;
        if (rstn && rvalid && rready) begin
            if (exp_r.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL r_unexpected: actual rdata=%0h required none", rdata);
            end else begin
                e = exp_r.pop_front();
                chk("rdata", rdata, e[31:0]);
                chk("rresp", 32'(rresp), 32'(e[33:32]));
            end
        end
    end

    task automatic drive_aw(input logic [31:0] a, input int dly);
        repeat (dly) begin
            @(negedge clk);
            if (bvalid) pre_b_bad = 1'b1;
            @(posedge clk);
            #1;
        end
        awaddr  = a;
        awvalid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bvalid) pre_b_bad = 1'b1;
            if (awready) begin
                @(posedge clk);
                #1;
                awvalid = 1'b0;
                return;
            end
        end
        awvalid = 1'b0;
        fail_now("aw_timeout");
    endtask

    task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        repeat (dly) begin
            @(negedge clk);
            if (bvalid) pre_b_bad = 1'b1;
            @(posedge clk);
            #1;
        end
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bvalid) pre_b_bad = 1'b1;
            if (wready) begin
                @(posedge clk);
                #1;
                wvalid = 1'b0;
                return;
            end
        end
        wvalid = 1'b0;
        fail_now("w_timeout");
    endtask

    task automatic drive_ar(input logic [31:0] a);
        araddr  = a;
        arvalid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (arready) begin
                @(posedge clk);
                #1;
                arvalid = 1'b0;
                return;
            end
        end
        arvalid = 1'b0;
        fail_now("ar_timeout");
    endtask

    // skew > 0: W leads AW by skew cycles; skew < 0: AW leads W.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int skew, input bit hold);
        bit            hit;
        int            i;
        logic [1:0]    eb;
        logic [NR-1:0] pulse;
        bit            got;
        hit = m_hit(a);
        i   = m_idx(a);
        eb  = hit ? 2'b00 : 2'b10;
        exp_b.push_back(eb);
        bready    = !hold;
        pre_b_bad = 1'b0;
        fork
            drive_aw(a, (skew > 0) ? skew : 0);
            drive_w(d, s, (skew < 0) ? -skew : 0);
        join
        if (hit) begin
            for (int b = 0; b < 4; b++) begin
                if (!STRB_EN || s[b]) mdl[i][8*b +: 8] = d[8*b +: 8];
            end
        end
        pulse = {NR{1'b0}};
        if (hit) pulse[i] = 1'b1;
        chk("bvalid_after_last_hs", 32'(bvalid), 32'(1));
        chk("bvalid_low_before_last_hs", 32'(pre_b_bad), 32'(0));
        chk("wr_pulse", 32'(wr_pulse), 32'(pulse));
        chk_regs("regs_after_write");
        if (hold) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                chk("bvalid_stall", 32'(bvalid), 32'(1));
                chk("bresp_stall", 32'(bresp), 32'(eb));
                chk("awready_stall", 32'(awready), 32'(0));
                chk("wready_stall", 32'(wready), 32'(0));
            end
            @(posedge clk);
            #1;
            bready = 1'b1;
        end
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (bvalid && bready) got = 1'b1;
        end
        if (!got) fail_now("b_timeout");
        @(posedge clk);
        #1;
        chk("wr_pulse_one_cycle", 32'(wr_pulse), 32'(0));
        chk("bvalid_drop", 32'(bvalid), 32'(0));
    endtask

    task automatic do_read(input logic [31:0] a, input bit hold);
        bit          hit;
        logic [31:0] ed;
        logic [1:0]  er;
        bit          got;
        hit = m_hit(a);
        ed  = hit ? mdl[m_idx(a)] : 32'h0;
        er  = hit ? 2'b00 : 2'b10;
        exp_r.push_back({er, ed});
        rready = !hold;
        drive_ar(a);
        chk("rvalid_after_ar", 32'(rvalid), 32'(1));
        chk("arready_busy", 32'(arready), 32'(0));
        if (hold) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                chk("rvalid_stall", 32'(rvalid), 32'(1));
                chk("rdata_stall", rdata, ed);
                chk("rresp_stall", 32'(rresp), 32'(er));
            end
            @(posedge clk);
            #1;
            rready = 1'b1;
        end
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (rvalid && rready) got = 1'b1;
        end
        if (!got) fail_now("r_timeout");
        @(posedge clk);
        #1;
        chk("rvalid_drop", 32'(rvalid), 32'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_awready"}, 32'(awready), 32'(0));
        chk({tag, "_wready"}, 32'(wready), 32'(0));
        chk({tag, "_arready"}, 32'(arready), 32'(0));
        chk({tag, "_bvalid"}, 32'(bvalid), 32'(0));
        chk({tag, "_rvalid"}, 32'(rvalid), 32'(0));
        chk({tag, "_bresp"}, 32'(bresp), 32'(0));
        chk({tag, "_rresp"}, 32'(rresp), 32'(0));
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_wr_pulse"}, 32'(wr_pulse), 32'(0));
        chk_regs({tag, "_regs"});
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'(4 * NR) + 32'($urandom_range(0, 63));
        if (r == 1) return 32'h8000_0000 | 32'($urandom_range(0, 31));
        return 32'($urandom_range(0, 4 * NR - 1));
    endfunction

    initial begin
        for (int k = 0; k < NR; k++) mdl[k] = 32'h0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("awready_before_first_edge", 32'(awready), 32'(0));
        @(posedge clk);
        #1;
        chk("awready_after_release", 32'(awready), 32'(1));
        chk("wready_after_release", 32'(wready), 32'(1));
        chk("arready_after_release", 32'(arready), 32'(1));

        do_write(32'h0000_000C, 32'hDEADBEEF, 4'hF, 0, 1'b0);
        chk("reg3_literal", regs[127:96], 32'hDEADBEEF);
        do_read(32'h0000_000C, 1'b0);

        do_write(32'h0000_0008, $urandom, 4'hF, 5, 1'b0);
        do_write(32'h0000_0010, $urandom, 4'hF, -5, 1'b0);
        do_read(32'h0000_0008, 1'b0);

        do_write(32'(4 * NR), 32'h1234_5678, 4'hF, 0, 1'b0);
        do_read(32'(4 * NR), 1'b0);
        do_write(32'h8000_0004, 32'h0BAD_0BAD, 4'hF, 0, 1'b0);

        do_write(32'h0000_0000, 32'h1122_3344, 4'hF, 0, 1'b0);
        do_write(32'h0000_0000, 32'hAABB_CCDD, 4'b0101, 0, 1'b0);
        chk("strobe_literal", regs[31:0], STRB_EN ? 32'h11BB_33DD : 32'hAABB_CCDD);
        do_write(32'h0000_0000, 32'h5555_AAAA, 4'b0000, 0, 1'b0);

        do_write(32'h0000_0004, $urandom, 4'hF, 0, 1'b1);
        do_read(32'h0000_0004, 1'b1);

        do_write(32'h0000_001C, 32'h7777_0001, 4'hF, 0, 1'b0);
        fork
            do_write(32'h0000_001C, 32'h7777_0002, 4'hF, 0, 1'b0);
            do_read(32'h0000_001C, 1'b0);
        join

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                         int'($urandom_range(0, 6)) - 3, $urandom_range(0, 7) == 0);
            end else begin
                do_read(rand_addr(), $urandom_range(0, 7) == 0);
            end
        end

        do_write(32'h0000_0014, 32'hCAFE_F00D, 4'hF, 0, 1'b0);
        drive_aw(32'h0000_0014, 0);
        chk("awready_in_addr_wait", 32'(awready), 32'(0));
        chk("wready_in_addr_wait", 32'(wready), 32'(1));
        #2;
        rstn = 1'b0;
        for (int k = 0; k < NR; k++) mdl[k] = 32'h0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        do_read(32'h0000_0014, 1'b0);
        do_write(32'h0000_0018, 32'h0102_0304, 4'hF, 0, 1'b0);
        do_read(32'h0000_0018, 1'b0);

        repeat (3) @(posedge clk);
        chk("b_queue_drained", 32'(exp_b.size()), 32'(0));
        chk("r_queue_drained", 32'(exp_r.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi4l_reg_slave.md
# axi4l_reg_slave

AXI4-Lite responder exposing `NUM_REGS` 32-bit read/write control registers to fabric logic; it is the target-side counterpart of the `axi4l_if` BFM initiator. It decodes accesses with the same base-offset/mask scheme as `uart_wrapper`. It sits beside the UART on the AXI4-Lite interconnect and drives static configuration into neighbouring blocks.

## Interface
- `BASE_OFFSET`, 64'h0: base address; a hit requires `(addr & BASE_OFFSET_MASK) == BASE_OFFSET`.
- `BASE_OFFSET_MASK`, 64'h0: upper-address decode mask.
- `ADDR_WIDTH`, 32: AXI address width.
- `DATA_WIDTH`, 32: AXI data width; only 32 is supported, and elaboration errors on anything else.
- `NUM_REGS`, 8: register count, a power of two from 2 to 256.
- `clk` in 1: single clock.
- `rstn` in 1: asynchronous, active-low reset.
- `awaddr` in ADDR_WIDTH / `awvalid` in 1 / `awready` out 1: write-address channel.
- `wdata` in 32 / `wstrb` in 4 / `wvalid` in 1 / `wready` out 1: write-data channel.
- `bresp` out 2 / `bvalid` out 1 / `bready` in 1: write-response channel.
- `araddr` in ADDR_WIDTH / `arvalid` in 1 / `arready` out 1: read-address channel.
- `rdata` out 32 / `rresp` out 2 / `rvalid` out 1 / `rready` in 1: read-data channel.
- `regs` out NUM_REGS*32: flattened register contents; register i occupies bits [32i+31:32i].
- `wr_pulse` out NUM_REGS: one-cycle strobe for each register written.

## Operation
- Register index is `addr[$clog2(NUM_REGS)+1:2]`. Address bits [1:0] are ignored.
- A decode miss, or any address bit between the index field and the mask that is set, returns SLVERR (2'b10).
  - A write that misses is dropped.
  - A read that misses returns `rdata` = 0.
- A hit returns OKAY (2'b00).

**Write FSM**
- States and outputs:
  - `W_IDLE`: `awready` = 1, `wready` = 1.
  - `W_ADDR`: address held, waiting for data; `wready` = 1 only.
  - `W_DATA`: data held, waiting for address; `awready` = 1 only.
  - `W_RESP`: `bvalid` = 1.
- Transitions:
  - From `W_IDLE`, AW and W accepted on the same edge go directly to `W_RESP`.
  - `W_RESP` returns to `W_IDLE` on `bvalid && bready`.
- The register update and the `wr_pulse` bit both occur on the edge where the second of the AW/W handshakes completes.

**Read FSM**
- `R_IDLE`: `arready` = 1.
- On the AR handshake, `rdata`/`rresp` are registered and the FSM moves to `R_DATA` with `rvalid` = 1.
- `R_DATA` returns to `R_IDLE` on `rready`.

**Boundary behaviour**
- The read and write paths are independent.
- A read and a write to the same register completing on the same edge: the read returns the pre-write value.
- Outputs held across stall: `bresp`, `rdata` and `rresp` stay stable while their valid is high and ready is low.

## Timing
- While `rstn` = 0, all outputs are 0, all `regs` are 0 and both FSMs are in their idle states.
- The readies assert on the first `clk` edge after `rstn` deasserts, via a registered `ready_en` flag.
- Write latency: if the last AW/W handshake is at edge N, `bvalid` is high after edge N. The earliest accepted `bready` is at edge N+1, and the next AW can be accepted at edge N+2.
- Read latency: if the AR handshake is at edge N, `rvalid` is high after edge N. Sustained throughput is one read per 2 cycles.
- `regs` reflects a write immediately after the update edge, and `wr_pulse` is high for exactly that one cycle.
- Reset asserted mid-transaction aborts it: all valids and readies drop asynchronously, and no partial write is committed.

## Configuration
- Macro: `AXI4L_REG_SLAVE_WSTRB_EN`.
- Defined: each byte lane of a register is written only where `wstrb[b]` = 1. `wstrb` = 4'b0000 leaves the register unchanged but still pulses `wr_pulse` and returns OKAY.
- Undefined: `wstrb` is ignored and all 4 bytes are written.

## Structure
- `axi4l_pkg` holds:
  - the `axi4l_resp_t` enum (OKAY = 2'b00, SLVERR = 2'b10);
  - the write/read state enums;
  - an `addr_hit()` function implementing the base/mask decode, shared with `uart_wrapper`.
- One natural sub-module: `axi4l_reg_slave_decode`, combinational address-to-index and hit/miss logic, instantiated once per channel.

## Test plan
- **Single write then read.** Write 0xDEADBEEF to reg 3 (AW and W together, `bready` = 1), then read reg 3.
  - `bresp` = OKAY.
  - `regs[127:96]` = 0xDEADBEEF.
  - `wr_pulse[3]` is high for 1 cycle.
  - The read returns `rdata` = 0xDEADBEEF with `rresp` = OKAY.
- **Skewed channels.** Present W 5 cycles before AW, then AW 5 cycles before W.
  - Both writes complete.
  - Each `bvalid` rises the cycle after the late handshake.
- **Out-of-range access.**
  - A write to BASE_OFFSET + 4*NUM_REGS returns `bresp` = SLVERR and leaves `regs` unchanged.
  - A read of BASE_OFFSET + 4*NUM_REGS returns SLVERR with `rdata` = 0.
- **Strobes.** Reg 0 = 0x11223344; write 0xAABBCCDD with `wstrb` = 4'b0101.
  - With `AXI4L_REG_SLAVE_WSTRB_EN` defined: reg 0 = 0x11BB33DD.
  - Without it: reg 0 = 0xAABBCCDD.
- **Backpressure.** Hold `bready`/`rready` low for 10 cycles.
  - `bvalid`/`rvalid`, `bresp`, `rdata` and `rresp` stay stable.
  - `awready` and `wready` stay 0 throughout.
- **Reset mid-write.** Pull `rstn` low after an AW handshake but before W.
  - All outputs go to 0 immediately.
  - After release, reading the target register returns 0.
